// File: rtl/iod_rd_dly_train_ctrl_if.sv
// ---------------------------------------------------------------------------
// iod_rd_dly_train_ctrl_if
//
// Groups the signals between the read-training sequencer, the DDR training
// FSM and the IOD (delay line + eye monitor) of one lane.
//
//   slave  : the sequencer itself (iod_rd_dly_train_ctrl)
//   master : the environment driving it (training FSM and IOD)
//
// Signals
//   START                    training FSM -> seq : one-cycle start pulse
//   ABORT                    training FSM -> seq : level, terminates training
//   EYE_MONITOR_EARLY        IOD -> seq          : eye-monitor early flag
//   EYE_MONITOR_LATE         IOD -> seq          : eye-monitor late flag
//   DELAY_LINE_OUT_OF_RANGE  IOD -> seq          : delay-line limit reached
//   DELAY_LINE_LOAD          seq -> IOD          : pulse, delay line to tap 0
//   DELAY_LINE_MOVE          seq -> IOD          : pulse, move one tap
//   DELAY_LINE_DIRECTION     seq -> IOD          : 1 = up, 0 = down (with MOVE)
//   EYE_MONITOR_CLEAR_FLAGS  seq -> IOD          : pulse, clear EARLY/LATE
//   BUSY / DONE / ERR        seq -> training FSM : status
//   TAP_OUT[7:0]             seq -> training FSM : final tap
//   EYE_WIDTH[8:0]           seq -> training FSM : passing window width
// ---------------------------------------------------------------------------
interface iod_rd_dly_train_ctrl_if;
    logic       START;
    logic       ABORT;
    logic       EYE_MONITOR_EARLY;
    logic       EYE_MONITOR_LATE;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [7:0] TAP_OUT;
    logic [8:0] EYE_WIDTH;

    modport slave (
        input  START,
        input  ABORT,
        input  EYE_MONITOR_EARLY,
        input  EYE_MONITOR_LATE,
        input  DELAY_LINE_OUT_OF_RANGE,
        output DELAY_LINE_LOAD,
        output DELAY_LINE_MOVE,
        output DELAY_LINE_DIRECTION,
        output EYE_MONITOR_CLEAR_FLAGS,
        output BUSY,
        output DONE,
        output ERR,
        output TAP_OUT,
        output EYE_WIDTH
    );

    modport master (
        output START,
        output ABORT,
        output EYE_MONITOR_EARLY,
        output EYE_MONITOR_LATE,
        output DELAY_LINE_OUT_OF_RANGE,
        input  DELAY_LINE_LOAD,
        input  DELAY_LINE_MOVE,
        input  DELAY_LINE_DIRECTION,
        input  EYE_MONITOR_CLEAR_FLAGS,
        input  BUSY,
        input  DONE,
        input  ERR,
        input  TAP_OUT,
        input  EYE_WIDTH
    );
endinterface

// File: rtl/iod_rd_dly_train_ctrl.sv
// ---------------------------------------------------------------------------
// iod_rd_dly_train_ctrl
//
// Per-lane read-training sequencer for the DDR4 PHY IOD read path. Sweeps the
// IOD input delay line upward from tap 0, classifies every tap as pass/fail
// from the eye-monitor EARLY/LATE flags, locates the first contiguous passing
// window and walks the delay line back down to the window centre.
//
// Ports
//   FAB_CLK   : lane fabric clock (only clock)
//   SYNC_RST  : synchronous, active-high reset
//   bus       : iod_rd_dly_train_ctrl_if.slave - start/abort from the training
//               FSM, eye-monitor and delay-line handshakes with the IOD, and
//               BUSY/DONE/ERR/TAP_OUT/EYE_WIDTH status back to the FSM
//
// Parameters
//   MAX_TAP       : highest tap index swept (8-bit tap counter)
//   SETTLE_CYCLES : wait cycles after a flag clear before sampling (>= 1)
//   SAMPLE_CYCLES : cycles EARLY/LATE are OR-accumulated per tap (>= 1)
//   MIN_EYE       : narrowest acceptable passing window, in taps
// ---------------------------------------------------------------------------
module iod_rd_dly_train_ctrl #(
    parameter int MAX_TAP       = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int MIN_EYE       = 4
) (
    input  logic                   FAB_CLK,
    input  logic                   SYNC_RST,
    iod_rd_dly_train_ctrl_if.slave bus
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]       MAX_TAP_L   = 8'(MAX_TAP);
    localparam logic [8:0]       MIN_EYE_L   = 9'(MIN_EYE);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_CENTER,
        S_ALIGN,
        S_MOVE_DN,
        S_DONE,
        S_FAIL
    } state_t;

    // Window width in taps; 9 bits so a full 256-tap window is representable.
    function automatic logic [8:0] eye_width_f(input logic [7:0] l, input logic [7:0] r);
        return {1'b0, r} - {1'b0, l} + 9'd1;
    endfunction

    // Floor of the window midpoint; the 9-bit sum cannot overflow.
    function automatic logic [7:0] eye_centre_f(input logic [7:0] l, input logic [7:0] r);
        logic [8:0] s;
        s = {1'b0, l} + {1'b0, r};
        return s[8:1];
    endfunction

    state_t           state;
    logic [7:0]       tap;
    logic [7:0]       left_tap;
    logic [7:0]       right_tap;
    logic             found_pass;
    logic             fail;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       width_r;
    logic [7:0]       target_r;

    logic             load_r;
    logic             move_r;
    logic             dir_r;
    logic             clear_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [7:0]       tap_out_r;
    logic [8:0]       eye_width_r;

    logic             pass_tap;
    logic             found_next;
    logic             sweep_end;
    logic [8:0]       width_c;
    logic [7:0]       target_c;

    assign pass_tap   = !fail;
    // found_pass as it will be once the current EVAL updates it; decides
    // CENTER vs FAIL when the sweep runs out on the very first passing tap.
    assign found_next = found_pass | pass_tap;
    assign sweep_end  = (tap == MAX_TAP_L) || bus.DELAY_LINE_OUT_OF_RANGE;
    assign width_c    = eye_width_f(left_tap, right_tap);
    assign target_c   = eye_centre_f(left_tap, right_tap);

    // All outputs are registered: a pulse output is set on the edge that
    // enters the state it belongs to, so it is high for exactly that state.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state       <= S_IDLE;
            tap         <= '0;
            left_tap    <= '0;
            right_tap   <= '0;
            found_pass  <= 1'b0;
            fail        <= 1'b0;
            cnt         <= '0;
            width_r     <= '0;
            target_r    <= '0;
            load_r      <= 1'b0;
            move_r      <= 1'b0;
            dir_r       <= 1'b0;
            clear_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            tap_out_r   <= '0;
            eye_width_r <= '0;
        end else begin
            load_r  <= 1'b0;
            move_r  <= 1'b0;
            dir_r   <= 1'b0;
            clear_r <= 1'b0;

            // Abort overrides every transition; the delay line stays where
            // it is because the next START always re-loads tap 0.
            if (state != S_IDLE && bus.ABORT) begin
                state  <= S_IDLE;
                busy_r <= 1'b0;
                err_r  <= 1'b1;
                done_r <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.START && !bus.ABORT) begin
                            state       <= S_LOAD;
                            load_r      <= 1'b1;
                            busy_r      <= 1'b1;
                            done_r      <= 1'b0;
                            err_r       <= 1'b0;
                            tap_out_r   <= '0;
                            eye_width_r <= '0;
                            found_pass  <= 1'b0;
                            left_tap    <= '0;
                            right_tap   <= '0;
                            width_r     <= '0;
                            target_r    <= '0;
                        end
                    end

                    S_LOAD: begin
                        tap     <= '0;
                        state   <= S_CLEAR;
                        clear_r <= 1'b1;
                    end

                    S_CLEAR: begin
                        fail  <= 1'b0;
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end

                    S_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= S_SAMPLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    S_SAMPLE: begin
                        // Sticky: one flagged cycle anywhere in the window fails the tap.
                        fail <= fail | bus.EYE_MONITOR_EARLY | bus.EYE_MONITOR_LATE;
                        if (cnt == SAMPLE_LAST) begin
                            cnt   <= '0;
                            state <= S_EVAL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    S_EVAL: begin
                        if (pass_tap && !found_pass) begin
                            left_tap   <= tap;
                            right_tap  <= tap;
                            found_pass <= 1'b1;
                        end else if (pass_tap) begin
                            right_tap <= tap;
                        end

                        if (!pass_tap && found_pass) begin
                            state <= S_CENTER;
                        end else if (sweep_end) begin
                            if (found_next) begin
                                state <= S_CENTER;
                            end else begin
                                state  <= S_FAIL;
                                load_r <= 1'b1;
                            end
                        end else begin
                            state  <= S_STEP;
                            move_r <= 1'b1;
                            dir_r  <= 1'b1;
                        end
                    end

                    S_STEP: begin
                        tap     <= tap + 8'd1;
                        state   <= S_CLEAR;
                        clear_r <= 1'b1;
                    end

                    S_CENTER: begin
                        width_r  <= width_c;
                        target_r <= target_c;
                        if (width_c < MIN_EYE_L) begin
                            state  <= S_FAIL;
                            load_r <= 1'b1;
                        end else begin
                            state <= S_ALIGN;
                        end
                    end

                    // ALIGN doubles as the idle gap between down-moves,
                    // giving a two-cycle MOVE spacing.
                    S_ALIGN: begin
                        if (tap == target_r) begin
                            state <= S_DONE;
                        end else begin
                            state  <= S_MOVE_DN;
                            move_r <= 1'b1;
                        end
                    end

                    S_MOVE_DN: begin
                        tap   <= tap - 8'd1;
                        state <= S_ALIGN;
                    end

                    S_DONE: begin
                        tap_out_r   <= target_r;
                        eye_width_r <= width_r;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= S_IDLE;
                    end

                    S_FAIL: begin
                        tap         <= '0;
                        tap_out_r   <= '0;
                        eye_width_r <= found_pass ? width_r : 9'd0;
                        done_r      <= 1'b1;
                        err_r       <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.DELAY_LINE_LOAD         = load_r;
    assign bus.DELAY_LINE_MOVE         = move_r;
    assign bus.DELAY_LINE_DIRECTION    = dir_r;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = clear_r;
    assign bus.BUSY                    = busy_r;
    assign bus.DONE                    = done_r;
    assign bus.ERR                     = err_r;
    assign bus.TAP_OUT                 = tap_out_r;
    assign bus.EYE_WIDTH               = eye_width_r;

endmodule

// File: tb/tb_iod_rd_dly_train_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iod_rd_dly_train_ctrl
//
// Directed bench for iod_rd_dly_train_ctrl with a behavioural IOD: a delay
// line that follows LOAD/MOVE/DIRECTION, and an eye monitor that flags
// EARLY on taps outside a pass mask, an optional one-cycle LATE glitch and
// an optional out-of-range tap. Expected results of each training run are
// queued when the run is started and checked when DONE appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iod_rd_dly_train_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iod_rd_dly_train_ctrl_if bus();

    iod_rd_dly_train_ctrl #(
        .MAX_TAP      (31),
        .SETTLE_CYCLES(2),
        .SAMPLE_CYCLES(4),
        .MIN_EYE      (4)
    ) dut (
        .FAB_CLK (clk),
        .SYNC_RST(rst),
        .bus     (bus)
    );

    typedef struct {
        int tap;
        int width;
        int err;
        int ups;
        int dns;
        int loads;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // IOD model configuration
    logic [31:0] pass_mask = 32'd0;
    logic        oor_on    = 1'b0;
    logic [7:0]  oor_tap   = 8'd0;
    logic        glitch_on = 1'b0;

    // IOD model state and pulse statistics
    logic [7:0] tap_m      = 8'd0;
    int         since_move = 100;
    int         cyc        = 0;
    int         ups        = 0;
    int         dns        = 0;
    int         loads      = 0;
    int         clears     = 0;
    int         viol       = 0;
    int         up_gap_bad = 0;
    int         dn_gap_bad = 0;
    int         last_up    = -1;
    int         last_dn    = -1;
    logic       prev_ld    = 1'b0;
    logic       prev_mv    = 1'b0;
    logic       prev_cl    = 1'b0;

    assign bus.EYE_MONITOR_EARLY       = !pass_mask[tap_m[4:0]];
    // Sampling window for a tap is since_move = 4..7; 5 hits its second cycle.
    assign bus.EYE_MONITOR_LATE        = glitch_on && (tap_m == 8'd15) && (since_move == 5);
    assign bus.DELAY_LINE_OUT_OF_RANGE = oor_on && (tap_m == oor_tap);

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if ((int'(bus.DELAY_LINE_LOAD) + int'(bus.DELAY_LINE_MOVE) + int'(bus.EYE_MONITOR_CLEAR_FLAGS)) > 1 ||
            (bus.DELAY_LINE_LOAD && prev_ld) || (bus.DELAY_LINE_MOVE && prev_mv) ||
            (bus.EYE_MONITOR_CLEAR_FLAGS && prev_cl))
            viol <= viol + 1;
        prev_ld <= bus.DELAY_LINE_LOAD;
        prev_mv <= bus.DELAY_LINE_MOVE;
        prev_cl <= bus.EYE_MONITOR_CLEAR_FLAGS;
        if (bus.EYE_MONITOR_CLEAR_FLAGS) clears <= clears + 1;
        if (bus.DELAY_LINE_MOVE) since_move <= 0;
        else                     since_move <= since_move + 1;
        if (bus.DELAY_LINE_LOAD) begin
            loads   <= loads + 1;
            tap_m   <= 8'd0;
            last_up <= -1;
            last_dn <= -1;
        end else if (bus.DELAY_LINE_MOVE) begin
            if (bus.DELAY_LINE_DIRECTION) begin
                ups   <= ups + 1;
                tap_m <= tap_m + 8'd1;
                if (last_up >= 0 && (cyc - last_up) != 9) up_gap_bad <= up_gap_bad + 1;
                last_up <= cyc;
            end else begin
                dns   <= dns + 1;
                tap_m <= tap_m - 8'd1;
                if (last_dn >= 0 && (cyc - last_dn) != 2) dn_gap_bad <= dn_gap_bad + 1;
                last_dn <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    task automatic run_scn(input string name, input logic [31:0] mask, input logic o_on,
                           input logic [7:0] o_tap, input logic gl, input exp_t e);
        int   b_up, b_dn, b_ld, b_v, b_ug, b_dg;
        bit   seen;
        exp_t got;
        pass_mask = mask;
        oor_on    = o_on;
        oor_tap   = o_tap;
        glitch_on = gl;
        sb_q.push_back(e);
        b_up = ups; b_dn = dns; b_ld = loads; b_v = viol; b_ug = up_gap_bad; b_dg = dn_gap_bad;
        start_pulse();
        chk({name, "_busy_rise"}, bus.BUSY, 1);
        chk({name, "_load_first"}, bus.DELAY_LINE_LOAD, 1);
        chk({name, "_done_clr"}, bus.DONE, 0);
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            if (bus.DONE) seen = 1;
        end
        chk({name, "_done"}, bus.DONE, 1);
        got = sb_q.pop_front();
        chk({name, "_busy_fall"}, bus.BUSY, 0);
        chk({name, "_tap_out"}, bus.TAP_OUT, got.tap);
        chk({name, "_eye_width"}, bus.EYE_WIDTH, got.width);
        chk({name, "_err"}, bus.ERR, got.err);
        chk({name, "_up_moves"}, ups - b_up, got.ups);
        chk({name, "_dn_moves"}, dns - b_dn, got.dns);
        chk({name, "_loads"}, loads - b_ld, got.loads);
        chk({name, "_pulse_rules"}, viol - b_v, 0);
        chk({name, "_up_spacing"}, up_gap_bad - b_ug, 0);
        chk({name, "_dn_spacing"}, dn_gap_bad - b_dg, 0);
        repeat (3) tick();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_up, b_ld, b_cl;
        rst       = 1'b1;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_load", bus.DELAY_LINE_LOAD, 0);
        chk("rst_move", bus.DELAY_LINE_MOVE, 0);
        chk("rst_dir", bus.DELAY_LINE_DIRECTION, 0);
        chk("rst_clear", bus.EYE_MONITOR_CLEAR_FLAGS, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_err", bus.ERR, 0);
        chk("rst_tap_out", bus.TAP_OUT, 0);
        chk("rst_eye_width", bus.EYE_WIDTH, 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: window 10..20, centre 15
        run_scn("s1_win10_20", 32'h001F_FC00, 1'b0, 8'd0, 1'b0, '{15, 11, 0, 21, 6, 1});
        // 2: no passing tap anywhere
        run_scn("s2_noeye", 32'h0000_0000, 1'b0, 8'd0, 1'b0, '{0, 0, 1, 31, 0, 2});
        // 3: every tap passes, window 0..31
        run_scn("s3_allpass", 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b0, '{15, 32, 0, 31, 16, 1});
        // 4: pass from 5, delay line out of range at 12
        run_scn("s4_oor12", 32'hFFFF_FFE0, 1'b1, 8'd12, 1'b0, '{8, 8, 0, 12, 4, 1});
        // 5a: narrow window 10..11
        run_scn("s5a_narrow", 32'h0000_0C00, 1'b0, 8'd0, 1'b0, '{0, 2, 1, 12, 0, 2});
        // 5b: window 10..20 with a one-cycle LATE glitch at tap 15
        run_scn("s5b_glitch", 32'h001F_FC00, 1'b0, 8'd0, 1'b1, '{12, 5, 0, 15, 3, 1});

        // 6: abort during SAMPLE at tap 7, with a START ignored while busy
        pass_mask = 32'h001F_FC00;
        oor_on    = 1'b0;
        glitch_on = 1'b0;
        b_up = ups; b_ld = loads;
        start_pulse();
        repeat (20) tick();
        start_pulse();
        for (int i = 0; i < 500 && !(tap_m == 8'd7 && since_move == 4); i++) tick();
        chk("s6_reach_tap7", {24'd0, tap_m}, 7);
        bus.ABORT = 1'b1;
        tick();
        chk("s6_abort_busy", bus.BUSY, 0);
        chk("s6_abort_err", bus.ERR, 1);
        chk("s6_abort_done", bus.DONE, 0);
        chk("s6_abort_load", bus.DELAY_LINE_LOAD, 0);
        chk("s6_abort_move", bus.DELAY_LINE_MOVE, 0);
        chk("s6_abort_clear", bus.EYE_MONITOR_CLEAR_FLAGS, 0);
        chk("s6_busy_start_ignored", loads - b_ld, 1);
        chk("s6_ups_before_abort", ups - b_up, 7);
        bus.ABORT = 1'b0;
        b_up = ups; b_ld = loads; b_cl = clears;
        repeat (5) tick();
        chk("s6_quiet_pulses", (ups - b_up) + (loads - b_ld) + (clears - b_cl), 0);

        // START together with ABORT in IDLE is ignored
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        chk("s6_start_abort_busy", bus.BUSY, 0);
        chk("s6_start_abort_load", bus.DELAY_LINE_LOAD, 0);
        chk("s6_start_abort_err", bus.ERR, 1);
        tick();

        // Restart after abort completes like scenario 1
        run_scn("s6_rerun", 32'h001F_FC00, 1'b0, 8'd0, 1'b0, '{15, 11, 0, 21, 6, 1});

        // Synchronous reset in the middle of a sweep
        start_pulse();
        repeat (30) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", bus.BUSY, 0);
        chk("midrst_pulses", {29'd0, bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE, bus.EYE_MONITOR_CLEAR_FLAGS}, 0);
        chk("midrst_done", bus.DONE, 0);
        chk("midrst_err", bus.ERR, 0);
        rst = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
